read_packet_from_mem: RTL and testbench

READ_PACKET_FROM_MEM -- requirements
Module: read_packet_from_mem

---
 rtl/eth_pkg.sv | 16 +
 rtl/byte_down_counter.sv | 33 +++
 rtl/read_packet_from_mem.sv | 149 ++++++++++++++
 tb/tb_read_packet_from_mem.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the packet reader: FSM state encoding and the
// Ethernet preamble / start-of-frame delimiter bytes.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_IFG  = 2'd3
    } state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         PRE_LEN       = 8;

endpackage

// File: rtl/byte_down_counter.sv
// Loadable down-counter that stops at zero; the zero flag marks the final
// count of whatever phase loaded it.
module byte_down_counter #(
    parameter int pW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [pW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [pW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - pW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/read_packet_from_mem.sv
// Reads length-prefixed packets out of a round buffer and streams them as
// preamble + SFD + payload bytes, followed by a fixed inter-frame gap.
module read_packet_from_mem
    import eth_pkg::*;
#(
    parameter int pRB_WIDHT  = 14,
    parameter int pFIFO_SIZE = 16,
    parameter int pMEM_WIDTH = 8,
    parameter int pIFG       = 12
) (
    input  logic                  iclk,
    input  logic                  i_rst,
    input  logic                  ienable,
    input  logic                  ififo_empty,
    input  logic [pFIFO_SIZE-1:0] ilen_pac,
    output logic                  ofifo_rd,
    output logic [pRB_WIDHT-1:0]  or_addr,
    input  logic [pMEM_WIDTH-1:0] ir_data,
    output logic                  otx_en,
    output logic [pMEM_WIDTH-1:0] otx_d,
    output logic                  obusy,
    output logic                  opkt_done
);

    state_t                  state_q, state_d;
    logic [pFIFO_SIZE-1:0]   len_q, len_d;
    logic [pRB_WIDHT-1:0]    rd_ptr_q, rd_ptr_d;
    logic [pRB_WIDHT-1:0]    or_addr_q, or_addr_d;
    logic                    otx_en_q, otx_en_d;
    logic [pMEM_WIDTH-1:0]   otx_d_q, otx_d_d;
    logic                    fifo_rd_q, fifo_rd_d;
    logic                    pkt_done_q, pkt_done_d;

    logic                    cnt_load, cnt_dec, cnt_zero;
    logic [pFIFO_SIZE-1:0]   cnt_load_val;
    logic                    start_ok, start_now;

    // One counter serves all three timed phases; each phase reloads it on entry.
    byte_down_counter #(
        .pW(pFIFO_SIZE)
    ) u_cnt (
        .clk      (iclk),
        .rst      (i_rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        rd_ptr_d     = rd_ptr_q;
        or_addr_d    = or_addr_q;
        otx_en_d     = 1'b0;
        otx_d_d      = '0;
        fifo_rd_d    = 1'b0;
        pkt_done_d   = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        start_ok     = ienable && !ififo_empty;
        start_now    = 1'b0;

        case (state_q)
            ST_IDLE: start_now = start_ok;
            ST_PRE: begin
                // A zero-length entry has already been popped; just drop it.
                if (len_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    otx_en_d  = 1'b1;
                    otx_d_d   = cnt_zero ? pMEM_WIDTH'(SFD_BYTE) : pMEM_WIDTH'(PREAMBLE_BYTE);
                    or_addr_d = rd_ptr_q;
                    if (cnt_zero) begin
                        state_d      = ST_DATA;
                        cnt_load     = 1'b1;
                        cnt_load_val = len_q - pFIFO_SIZE'(1);
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                otx_en_d  = 1'b1;
                otx_d_d   = ir_data;
                or_addr_d = or_addr_q + pRB_WIDHT'(1);
                if (cnt_zero) begin
                    // Address after the last byte is rd_ptr + len, wrapped.
                    rd_ptr_d     = or_addr_q + pRB_WIDHT'(1);
                    pkt_done_d   = 1'b1;
                    state_d      = ST_IFG;
                    cnt_load     = 1'b1;
                    cnt_load_val = pFIFO_SIZE'(pIFG - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_IFG: begin
                if (cnt_zero) begin
                    state_d   = ST_IDLE;
                    start_now = start_ok;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_now) begin
            state_d      = ST_PRE;
            len_d        = ilen_pac;
            fifo_rd_d    = 1'b1;
            or_addr_d    = rd_ptr_q;
            cnt_load     = 1'b1;
            cnt_load_val = pFIFO_SIZE'(PRE_LEN - 1);
        end
    end

    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            rd_ptr_q   <= '0;
            or_addr_q  <= '0;
            otx_en_q   <= 1'b0;
            otx_d_q    <= '0;
            fifo_rd_q  <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_ptr_q   <= rd_ptr_d;
            or_addr_q  <= or_addr_d;
            otx_en_q   <= otx_en_d;
            otx_d_q    <= otx_d_d;
            fifo_rd_q  <= fifo_rd_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    assign ofifo_rd  = fifo_rd_q;
    assign or_addr   = or_addr_q;
    assign otx_en    = otx_en_q;
    assign otx_d     = otx_d_q;
    assign opkt_done = pkt_done_q;
    assign obusy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_read_packet_from_mem.sv
// Bench for read_packet_from_mem: FWFT length FIFO and round-buffer memory
// models, per-cycle output log, and a frame-level expected-stream model.
module tb_read_packet_from_mem;

    localparam int RB_W    = 14;
    localparam int RB_SIZE = 1 << RB_W;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        ienable;
    logic        ififo_empty;
    logic [15:0] ilen_pac;
    logic        ofifo_rd;
    logic [13:0] or_addr;
    logic [7:0]  ir_data;
    logic        otx_en;
    logic [7:0]  otx_d;
    logic        obusy;
    logic        opkt_done;

    int checks   = 0;
    int failures = 0;

    read_packet_from_mem dut (
        .iclk        (clk),
        .i_rst       (i_rst),
        .ienable     (ienable),
        .ififo_empty (ififo_empty),
        .ilen_pac    (ilen_pac),
        .ofifo_rd    (ofifo_rd),
        .or_addr     (or_addr),
        .ir_data     (ir_data),
        .otx_en      (otx_en),
        .otx_d       (otx_d),
        .obusy       (obusy),
        .opkt_done   (opkt_done)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:RB_SIZE-1];
    logic [15:0] fifo_mem [0:63];
    int          fifo_wr  = 0;
    int          fifo_rdp = 0;
    int          pop_empty_viol = 0;

    assign ififo_empty = (fifo_wr == fifo_rdp);
    assign ilen_pac    = fifo_mem[fifo_rdp % 64];
    assign ir_data     = mem[or_addr];

    always @(posedge clk) begin
        if (ofifo_rd) begin
            if (fifo_wr == fifo_rdp) pop_empty_viol <= pop_empty_viol + 1;
            fifo_rdp <= fifo_rdp + 1;
        end
    end

    typedef struct packed {
        logic        en;
        logic [7:0]  d;
        logic        done;
        logic        rd;
        logic        busy;
        logic [13:0] addr;
    } rec_t;

    rec_t log_q[$];

    always @(negedge clk)
        log_q.push_back(rec_t'{otx_en, otx_d, opkt_done, ofifo_rd, obusy, or_addr});

    int lens_q[$];
    int exp_ptr = 0;

    task automatic push_lens();
        @(negedge clk);
        foreach (lens_q[i]) begin
            fifo_mem[fifo_wr % 64] = 16'(lens_q[i]);
            fifo_wr++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst   = 1'b1;
        ienable = 1'b0;
        repeat (3) @(negedge clk);
        i_rst   = 1'b0;
        exp_ptr = 0;
        @(negedge clk);
    endtask

    // Enables the block long enough for every queued frame, then locates the first pop.
    task automatic drive_frames(output int s, output int t0);
        int total;
        total = 30;
        foreach (lens_q[i]) total += lens_q[i] + 20;
        @(negedge clk);
        s = log_q.size();
        ienable = 1'b1;
        repeat (total) @(negedge clk);
        ienable = 1'b0;
        t0 = -1;
        for (int i = s; i < log_q.size(); i++)
            if (log_q[i].rd && t0 < 0) t0 = i;
    endtask

    // Expected frame: pop cycle, 7x55, D5, len payload bytes, then 12 quiet
    // cycles with the next pop landing on the last of them.
    task automatic scan_frames(input int t0, input int n, output int derr, output int cerr,
                               output string why);
        int   t;
        int   len;
        int   span;
        bit   last;
        rec_t r;
        logic       e_en, e_done, e_rd, e_busy, chk_addr;
        logic [7:0] e_d;
        int         e_addr;
        t = t0; derr = 0; cerr = 0; why = "";
        for (int f = 0; f < n; f++) begin
            len  = lens_q[f];
            last = (f == n - 1);
            span = len + 20 + (last ? 1 : 0);
            if (t + span > log_q.size()) begin
                derr++;
                if (why == "") why = $sformatf("frame%0d log ends at %0d, need %0d", f, log_q.size(), t + span);
                break;
            end
            for (int i = 0; i < span; i++) begin
                r = log_q[t + i];
                e_en = 0; e_d = 8'h00; e_done = 0; e_rd = 0; e_busy = 1; chk_addr = 0; e_addr = 0;
                if (i == 0) e_rd = 1;
                else if (i <= 7) begin e_en = 1; e_d = 8'h55; end
                else if (i == 8) begin e_en = 1; e_d = 8'hD5; end
                else if (i <= 8 + len) begin
                    e_en = 1;
                    e_d = mem[(exp_ptr + i - 9) % RB_SIZE];
                    e_done = (i == 8 + len);
                end
                if (i >= 8 && i <= 7 + len) begin chk_addr = 1; e_addr = (exp_ptr + i - 8) % RB_SIZE; end
                if (i == len + 20) e_busy = 0;
                if (r.en !== e_en || r.d !== e_d) begin
                    derr++;
                    if (why == "") why = $sformatf("frame%0d cyc%0d en/d got %0b/%02h want %0b/%02h",
                                                   f, i, r.en, r.d, e_en, e_d);
                end
                if (r.done !== e_done || r.rd !== e_rd || r.busy !== e_busy ||
                    (chk_addr && r.addr !== 14'(e_addr))) begin
                    cerr++;
                    if (why == "") why = $sformatf("frame%0d cyc%0d done/rd/busy/addr got %0b/%0b/%0b/%0d want %0b/%0b/%0b/%0d",
                                                   f, i, r.done, r.rd, r.busy, r.addr, e_done, e_rd, e_busy, e_addr);
                end
            end
            exp_ptr = (exp_ptr + len) % RB_SIZE;
            t += len + 20;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; ienable = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (otx_en !== 1'b0) begin failures++; $display("FAIL reset_otx_en got %0b want 0", otx_en); end
        checks++; if (otx_d !== 8'h00) begin failures++; $display("FAIL reset_otx_d got %02h want 00", otx_d); end
        checks++; if (ofifo_rd !== 1'b0) begin failures++; $display("FAIL reset_ofifo_rd got %0b want 0", ofifo_rd); end
        checks++; if (opkt_done !== 1'b0) begin failures++; $display("FAIL reset_opkt_done got %0b want 0", opkt_done); end
        checks++; if (obusy !== 1'b0) begin failures++; $display("FAIL reset_obusy got %0b want 0", obusy); end
        checks++; if (or_addr !== 14'd0) begin failures++; $display("FAIL reset_or_addr got %0d want 0", or_addr); end
        i_rst = 1'b0; ienable = 1'b0;
    endtask

    task automatic test_single();
        int s, t0, derr, cerr, pops, ens;
        string why;
        do_reset();
        mem[0] = 8'hA1; mem[1] = 8'hA2; mem[2] = 8'hA3; mem[3] = 8'hA4;
        lens_q = '{4};
        push_lens();
        drive_frames(s, t0);
        checks++;
        if (t0 < 0) begin failures++; $display("FAIL single_pop got none want one"); end
        else begin
            scan_frames(t0, 1, derr, cerr, why);
            checks++; if (derr !== 0) begin failures++; $display("FAIL single_bytes errors=%0d want 0: %s", derr, why); end
            checks++; if (cerr !== 0) begin failures++; $display("FAIL single_ctrl errors=%0d want 0: %s", cerr, why); end
        end
        pops = 0; ens = 0;
        for (int i = s; i < log_q.size(); i++) begin
            pops += int'(log_q[i].rd);
            ens  += int'(log_q[i].en);
        end
        checks++; if (pops !== 1) begin failures++; $display("FAIL single_pop_count got %0d want 1", pops); end
        checks++; if (ens !== 12) begin failures++; $display("FAIL single_en_cycles got %0d want 12", ens); end
    endtask

    task automatic test_back_to_back();
        int s, t0, derr, cerr, nxt;
        string why;
        do_reset();
        lens_q = '{3, 5};
        push_lens();
        drive_frames(s, t0);
        checks++;
        if (t0 < 0) begin failures++; $display("FAIL b2b_pop got none want two"); end
        else begin
            scan_frames(t0, 2, derr, cerr, why);
            checks++; if (derr !== 0) begin failures++; $display("FAIL b2b_bytes errors=%0d want 0: %s", derr, why); end
            checks++; if (cerr !== 0) begin failures++; $display("FAIL b2b_ctrl errors=%0d want 0: %s", cerr, why); end
            nxt = -1;
            for (int i = t0 + 12; i < log_q.size(); i++)
                if (log_q[i].en && nxt < 0) nxt = i;
            checks++; if (nxt - (t0 + 12) !== 12) begin failures++; $display("FAIL b2b_gap got %0d want 12", nxt - (t0 + 12)); end
        end
    endtask

    task automatic test_zero_len();
        int s, p1, p2, pops, ens, derr, cerr;
        string why;
        do_reset();
        lens_q = '{0, 2};
        push_lens();
        @(negedge clk);
        s = log_q.size();
        ienable = 1'b1;
        repeat (60) @(negedge clk);
        ienable = 1'b0;
        pops = 0; p1 = -1; p2 = -1;
        for (int i = s; i < log_q.size(); i++)
            if (log_q[i].rd) begin
                pops++;
                if (p1 < 0) p1 = i; else if (p2 < 0) p2 = i;
            end
        checks++; if (pops !== 2) begin failures++; $display("FAIL zero_pop_count got %0d want 2", pops); end
        if (p2 >= 0) begin
            ens = 0;
            for (int i = p1; i <= p2; i++) ens += int'(log_q[i].en);
            checks++; if (ens !== 0) begin failures++; $display("FAIL zero_no_output got %0d en cycles want 0", ens); end
            lens_q = '{2};
            scan_frames(p2, 1, derr, cerr, why);
            checks++; if (derr !== 0) begin failures++; $display("FAIL zero_next_bytes errors=%0d want 0: %s", derr, why); end
            checks++; if (cerr !== 0) begin failures++; $display("FAIL zero_next_ctrl errors=%0d want 0: %s", cerr, why); end
        end
    endtask

    task automatic test_reset_mid();
        int found, s, s2, t0, pops, ens, derr, cerr;
        string why;
        do_reset();
        lens_q = '{10};
        push_lens();
        ienable = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (ofifo_rd) found = 1;
        end
        checks++;
        if (found == 0) begin failures++; $display("FAIL rstmid_pop got none want one"); end
        else begin
            repeat (11) @(posedge clk);
            #2;
            checks++; if (otx_en !== 1'b1 || otx_d !== mem[2]) begin
                failures++; $display("FAIL rstmid_third_byte got %0b/%02h want 1/%02h", otx_en, otx_d, mem[2]); end
            i_rst = 1'b1;
            ienable = 1'b0;
            #1;
            checks++; if (otx_en !== 1'b0) begin failures++; $display("FAIL rstmid_otx_en got %0b want 0", otx_en); end
            checks++; if (otx_d !== 8'h00) begin failures++; $display("FAIL rstmid_otx_d got %02h want 00", otx_d); end
            checks++; if (obusy !== 1'b0) begin failures++; $display("FAIL rstmid_obusy got %0b want 0", obusy); end
            checks++; if (or_addr !== 14'd0) begin failures++; $display("FAIL rstmid_or_addr got %0d want 0", or_addr); end
        end
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        exp_ptr = 0;
        lens_q = '{3};
        push_lens();
        s2 = log_q.size();
        repeat (20) @(negedge clk);
        pops = 0; ens = 0;
        for (int i = s2; i < log_q.size(); i++) begin
            pops += int'(log_q[i].rd);
            ens  += int'(log_q[i].en);
        end
        checks++; if (pops !== 0 || ens !== 0) begin
            failures++; $display("FAIL rstmid_quiet got pops=%0d en=%0d want 0/0", pops, ens); end
        drive_frames(s, t0);
        checks++;
        if (t0 < 0) begin failures++; $display("FAIL rstmid_restart got no pop want one"); end
        else begin
            scan_frames(t0, 1, derr, cerr, why);
            checks++; if (derr !== 0) begin failures++; $display("FAIL rstmid_restart_bytes errors=%0d want 0: %s", derr, why); end
            checks++; if (cerr !== 0) begin failures++; $display("FAIL rstmid_restart_ctrl errors=%0d want 0: %s", cerr, why); end
        end
    endtask

    task automatic test_enable_drop();
        int s, t, t0, pops, derr, cerr;
        string why;
        lens_q = '{6, 2};
        push_lens();
        s = log_q.size();
        ienable = 1'b1;
        t = -1;
        for (int i = 0; i < 20 && t < 0; i++) begin
            @(negedge clk);
            if (ofifo_rd) t = log_q.size() - 1;
        end
        repeat (3) @(negedge clk);
        ienable = 1'b0;
        repeat (70) @(negedge clk);
        t = -1;
        for (int i = s; i < log_q.size(); i++)
            if (log_q[i].rd && t < 0) t = i;
        checks++;
        if (t < 0) begin failures++; $display("FAIL endrop_pop got none want one"); end
        else begin
            scan_frames(t, 1, derr, cerr, why);
            checks++; if (derr !== 0) begin failures++; $display("FAIL endrop_bytes errors=%0d want 0: %s", derr, why); end
            checks++; if (cerr !== 0) begin failures++; $display("FAIL endrop_ctrl errors=%0d want 0: %s", cerr, why); end
            pops = 0;
            for (int i = t + 1; i < log_q.size(); i++) pops += int'(log_q[i].rd);
            checks++; if (pops !== 0) begin failures++; $display("FAIL endrop_no_pop got %0d want 0", pops); end
        end
        lens_q.delete(0);
        drive_frames(s, t0);
        checks++;
        if (t0 < 0) begin failures++; $display("FAIL endrop_resume got no pop want one"); end
        else begin
            scan_frames(t0, 1, derr, cerr, why);
            checks++; if (derr !== 0 || cerr !== 0) begin
                failures++; $display("FAIL endrop_resume_frame errors=%0d/%0d want 0/0: %s", derr, cerr, why); end
        end
    endtask

    task automatic test_random();
        int s, t0, derr, cerr;
        string why;
        for (int round = 0; round < 3; round++) begin
            lens_q.delete();
            for (int k = 0; k < 5; k++) lens_q.push_back(int'($urandom_range(1, 32)));
            push_lens();
            drive_frames(s, t0);
            checks++;
            if (t0 < 0) begin failures++; $display("FAIL random%0d_pop got none want some", round); end
            else begin
                scan_frames(t0, 5, derr, cerr, why);
                checks++; if (derr !== 0) begin failures++; $display("FAIL random%0d_bytes errors=%0d want 0: %s", round, derr, why); end
                checks++; if (cerr !== 0) begin failures++; $display("FAIL random%0d_ctrl errors=%0d want 0: %s", round, cerr, why); end
            end
        end
    endtask

    task automatic test_wrap();
        int s, t0, derr, cerr;
        string why;
        do_reset();
        lens_q = '{16382};
        push_lens();
        drive_frames(s, t0);
        checks++;
        if (t0 < 0) begin failures++; $display("FAIL wrap_fill_pop got none want one"); end
        else begin
            scan_frames(t0, 1, derr, cerr, why);
            checks++; if (derr !== 0 || cerr !== 0) begin
                failures++; $display("FAIL wrap_fill_frame errors=%0d/%0d want 0/0: %s", derr, cerr, why); end
        end
        lens_q = '{4, 1};
        push_lens();
        drive_frames(s, t0);
        checks++;
        if (t0 < 0) begin failures++; $display("FAIL wrap_pop got none want two"); end
        else begin
            scan_frames(t0, 2, derr, cerr, why);
            checks++; if (derr !== 0) begin failures++; $display("FAIL wrap_bytes errors=%0d want 0: %s", derr, why); end
            checks++; if (cerr !== 0) begin failures++; $display("FAIL wrap_ctrl errors=%0d want 0: %s", cerr, why); end
        end
    endtask

    initial begin
        i_rst   = 1'b1;
        ienable = 1'b0;
        for (int i = 0; i < RB_SIZE; i++) mem[i] = 8'($urandom);
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_len();
        test_reset_mid();
        test_enable_drop();
        test_random();
        test_wrap();
        checks++;
        if (pop_empty_viol !== 0) begin
            failures++; $display("FAIL pop_while_empty got %0d want 0", pop_empty_viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
